expr_eval: RTL
==============

# expr_eval

Token consumer placed directly downstream of the lexer. Accepts 16-bit tokens (tag + 8-bit value), parses statements of the form `NUM ((PLUS|MINUS) NUM)* SEMICOLON`, and emits one accumulated result per statement. Because the lexer cannot be stalled, a small input FIFO absorbs tokens while the result output is back-pressured. Overflow of that FIFO is reported as a sticky flag.

## Interface
- FIFO_DEPTH, 4: token FIFO entries; must be a power of 2, ≥2.
- ACC_W, 16: accumulator and result width; ≥10.
- CLK  in  1  clock.
- RST  in  1  synchronous, active-high reset.
- I_VALID  in  1  token strobe; no back-pressure toward the lexer.
- I_DATA  in  16  token; [15:8] tag, [7:0] value.
- O_VALID  out  1  result valid; held until accepted.
- O_DATA  out  ACC_W  statement result, two's complement.
- O_ERR  out  1  statement was malformed; qualified by O_VALID.
- O_READY  in  1  downstream accepts the result when O_VALID && O_READY.
- OVF  out  1  sticky; a token was dropped because the FIFO was full.

## Operation
- Tags: NUM=8'h00, PLUS=8'h01, MINUS=8'h02, SEMICOLON=8'h03. Any other tag is a syntax error.
- Token FIFO:
  - Push on I_VALID.
  - The evaluator pops the head when the FIFO is non-empty and not stalled.
  - Stall occurs only when the head is SEMICOLON and the output register is occupied and not being accepted in that cycle.
- FSM states:
  - S_NUM: expecting an operand.
    - NUM: acc ← acc ± value (sign taken from the pending op; the first operand loads). Go to S_OP.
    - Anything else: go to S_ERR. If the token was SEMICOLON, emit the error result immediately instead.
  - S_OP: expecting an operator.
    - PLUS/MINUS: latch the op, go to S_NUM.
    - SEMICOLON: emit acc with O_ERR=0, clear acc, go to S_NUM.
    - Anything else: go to S_ERR.
  - S_ERR: discard tokens until SEMICOLON. Then emit O_DATA=0, O_ERR=1, go to S_NUM.
- Arithmetic:
  - Value is zero-extended to ACC_W.
  - Add/subtract is modulo 2^ACC_W (see Configuration for the saturating option).
- FIFO overflow (push while full with no pop that cycle):
  - The incoming token is dropped and OVF is set.
  - The statement in progress is forced into S_ERR.
- Push while full with a simultaneous pop is legal: no drop, count unchanged.
- OVF clears only on RST.

## Timing
- Reset values: O_VALID=0, O_DATA=0, O_ERR=0, OVF=0, FIFO empty, state S_NUM, acc=0, pending op=PLUS.
- A token sampled at edge k is written to the FIFO at edge k.
- If the FIFO was empty and there is no stall, the token is evaluated at edge k+1.
- For SEMICOLON, O_VALID is high from edge k+1, giving 2-edge latency input→output.
- Throughput is one token per cycle.
- An O_VALID/O_READY handshake at edge e frees the output register at e. A new result may load at the same edge, so back-to-back results are possible.
- O_DATA and O_ERR are stable while O_VALID && !O_READY.
- RST mid-statement discards the FIFO contents, the partial accumulator and any pending result.

## Configuration
- EXPR_EVAL_SATURATE_EN defined: add/subtract saturates to the signed range [−2^(ACC_W−1), 2^(ACC_W−1)−1]. Saturation is applied at each step.
- Not defined: modulo-2^ACC_W wrap.
- No other behaviour changes.

## Structure
- Package expr_eval_pkg:
  - tag constants TAG_NUM, TAG_PLUS, TAG_MINUS, TAG_SEMICOLON;
  - token field positions (TAG_MSB/LSB, VAL_MSB/LSB);
  - FSM state encoding S_NUM, S_OP, S_ERR.
- Sub-module token_fifo:
  - synchronous FIFO, parameters FIFO_DEPTH and width 16;
  - ports: push, pop, full, empty, head, and an overflow pulse.
- The FSM, accumulator and output register live in expr_eval.

## Test plan
- Tokens 3, +, 5, −, 2, ; one per cycle with O_READY=1 → a single O_VALID pulse, O_DATA=6, O_ERR=0, 2 edges after the ';'.
- 10, −, 20, ; → O_DATA=16'hFFF6, O_ERR=0.
- +, 5, ; then 7, ; → first result O_DATA=0 with O_ERR=1, second O_DATA=7 with O_ERR=0.
- O_READY=0, two complete statements "1 ;" and "2 ;", then six further tokens pushed without gaps:
  - required: OVF=1, first result 1 held stable, and the statement hit by overflow reports O_ERR=1;
  - after O_READY=1, results drain in order.
- ACC_W=10, 255 + 255 + 255 ; →
  - without the macro: O_DATA=10'h2FD;
  - with EXPR_EVAL_SATURATE_EN: 10'h1FF.
- RST asserted for 1 cycle after "4 + " → all outputs 0. Then "9 ;" → O_DATA=9, O_ERR=0, with no residue from the aborted statement.

Source files
------------

// File: rtl/expr_eval_pkg.sv
// Shared definitions for the expr_eval token evaluator: token layout, tag codes
// and FSM/operator encodings.
package expr_eval_pkg;

   localparam int unsigned TOKEN_W = 16;
   localparam int unsigned TAG_MSB = 15;
   localparam int unsigned TAG_LSB = 8;
   localparam int unsigned VAL_MSB = 7;
   localparam int unsigned VAL_LSB = 0;

   localparam logic [7:0] TAG_NUM       = 8'h00;
   localparam logic [7:0] TAG_PLUS      = 8'h01;
   localparam logic [7:0] TAG_MINUS     = 8'h02;
   localparam logic [7:0] TAG_SEMICOLON = 8'h03;

   typedef enum logic [1:0] {
      S_NUM,
      S_OP,
      S_ERR
   } state_t;

   typedef enum logic {
      OP_PLUS,
      OP_MINUS
   } op_t;

endpackage

// File: rtl/expr_eval_if.sv
// Token input / result output bundle of expr_eval; master drives tokens and
// O_READY, slave is the evaluator.
interface expr_eval_if #(
   parameter int unsigned ACC_W = 16
);
   import expr_eval_pkg::*;

   logic               I_VALID;
   logic [TOKEN_W-1:0] I_DATA;
   logic               O_VALID;
   logic [ACC_W-1:0]   O_DATA;
   logic               O_ERR;
   logic               O_READY;
   logic               OVF;

   modport master (
      output I_VALID, I_DATA, O_READY,
      input  O_VALID, O_DATA, O_ERR, OVF
   );

   modport slave (
      input  I_VALID, I_DATA, O_READY,
      output O_VALID, O_DATA, O_ERR, OVF
   );

endinterface

// File: rtl/expr_eval_token_fifo.sv
// Synchronous token FIFO; a push while full is dropped unless a pop frees the
// slot in the same cycle, in which case o_overflow stays low.
module token_fifo #(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned WIDTH      = 16
) (
   input  logic             CLK,
   input  logic             RST,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic             o_full,
   output logic             o_empty,
   output logic [WIDTH-1:0] o_head,
   output logic             o_overflow
);
   localparam int unsigned AW = $clog2(FIFO_DEPTH);

   logic [WIDTH-1:0] r_mem [FIFO_DEPTH];
   logic [AW-1:0]    r_rd;
   logic [AW-1:0]    r_wr;
   logic [AW:0]      r_cnt;
   logic             w_do_pop;
   logic             w_do_push;

   assign o_empty    = (r_cnt == '0);
   assign o_full     = (r_cnt == (AW+1)'(FIFO_DEPTH));
   assign o_head     = r_mem[r_rd];
   assign w_do_pop   = i_pop && !o_empty;
   assign w_do_push  = i_push && (!o_full || w_do_pop);
   assign o_overflow = i_push && o_full && !w_do_pop;

   always_ff @(posedge CLK) begin
      if (w_do_push) begin
         r_mem[r_wr] <= i_data;
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_rd  <= '0;
         r_wr  <= '0;
         r_cnt <= '0;
      end else begin
         if (w_do_push) begin
            r_wr <= r_wr + AW'(1);
         end
         if (w_do_pop) begin
            r_rd <= r_rd + AW'(1);
         end
         r_cnt <= r_cnt + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
      end
   end

endmodule

// File: rtl/expr_eval.sv
// Statement evaluator behind the lexer: NUM ((PLUS|MINUS) NUM)* SEMICOLON -> one result.
// Define EXPR_EVAL_SATURATE_EN for per-step signed saturation instead of wrap.
module expr_eval
   import expr_eval_pkg::*;
#(
   parameter int unsigned FIFO_DEPTH = 4,
   parameter int unsigned ACC_W      = 16
) (
   input logic        CLK,
   input logic        RST,
   expr_eval_if.slave bus
);
   logic [TOKEN_W-1:0] w_head;
   logic               w_empty;
   logic               w_full;
   logic               w_ovf_pulse;
   logic               w_pop;
   logic               w_stall;
   logic               w_accept;
   logic [7:0]         w_tag;
   logic [ACC_W-1:0]   w_val_ext;
   logic [ACC_W-1:0]   w_sum;

   state_t             r_state;
   op_t                r_op;
   logic [ACC_W-1:0]   r_acc;
   logic               r_o_valid;
   logic [ACC_W-1:0]   r_o_data;
   logic               r_o_err;
   logic               r_ovf;

   token_fifo #(
      .FIFO_DEPTH(FIFO_DEPTH),
      .WIDTH     (TOKEN_W)
   ) u_fifo (
      .CLK       (CLK),
      .RST       (RST),
      .i_push    (bus.I_VALID),
      .i_data    (bus.I_DATA),
      .i_pop     (w_pop),
      .o_full    (w_full),
      .o_empty   (w_empty),
      .o_head    (w_head),
      .o_overflow(w_ovf_pulse)
   );

   assign w_tag     = w_head[TAG_MSB:TAG_LSB];
   assign w_val_ext = {{(ACC_W-8){1'b0}}, w_head[VAL_MSB:VAL_LSB]};
   assign w_accept  = r_o_valid && bus.O_READY;
   // Only a result-producing token can be blocked by an occupied output register.
   assign w_stall   = (w_tag == TAG_SEMICOLON) && r_o_valid && !bus.O_READY;
   assign w_pop     = !w_empty && !w_stall;

`ifdef EXPR_EVAL_SATURATE_EN
   logic [ACC_W:0] w_wide;
   assign w_wide = (r_op == OP_MINUS) ? ({r_acc[ACC_W-1], r_acc} - {1'b0, w_val_ext})
                                      : ({r_acc[ACC_W-1], r_acc} + {1'b0, w_val_ext});
   // Extra sign bit disagreeing with the result MSB means the signed range was left.
   assign w_sum  = (w_wide[ACC_W] == w_wide[ACC_W-1]) ? w_wide[ACC_W-1:0]
                 : (w_wide[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}});
`else
   assign w_sum = (r_op == OP_MINUS) ? (r_acc - w_val_ext) : (r_acc + w_val_ext);
`endif

   always_ff @(posedge CLK) begin
      if (RST) begin
         r_state   <= S_NUM;
         r_op      <= OP_PLUS;
         r_acc     <= '0;
         r_o_valid <= 1'b0;
         r_o_data  <= '0;
         r_o_err   <= 1'b0;
         r_ovf     <= 1'b0;
      end else begin
         if (w_accept) begin
            r_o_valid <= 1'b0;
         end
         if (w_pop) begin
            case (r_state)
               S_NUM: begin
                  if (w_tag == TAG_NUM) begin
                     r_acc   <= w_sum;
                     r_state <= S_OP;
                  end else if (w_tag == TAG_SEMICOLON) begin
                     r_o_valid <= 1'b1;
                     r_o_data  <= '0;
                     r_o_err   <= 1'b1;
                     r_acc     <= '0;
                     r_op      <= OP_PLUS;
                     r_state   <= S_NUM;
                  end else begin
                     r_state <= S_ERR;
                  end
               end
               S_OP: begin
                  if (w_tag == TAG_PLUS) begin
                     r_op    <= OP_PLUS;
                     r_state <= S_NUM;
                  end else if (w_tag == TAG_MINUS) begin
                     r_op    <= OP_MINUS;
                     r_state <= S_NUM;
                  end else if (w_tag == TAG_SEMICOLON) begin
                     r_o_valid <= 1'b1;
                     r_o_data  <= r_acc;
                     r_o_err   <= 1'b0;
                     r_acc     <= '0;
                     r_op      <= OP_PLUS;
                     r_state   <= S_NUM;
                  end else begin
                     r_state <= S_ERR;
                  end
               end
               S_ERR: begin
                  if (w_tag == TAG_SEMICOLON) begin
                     r_o_valid <= 1'b1;
                     r_o_data  <= '0;
                     r_o_err   <= 1'b1;
                     r_acc     <= '0;
                     r_op      <= OP_PLUS;
                     r_state   <= S_NUM;
                  end
               end
               default: begin
                  r_state <= S_NUM;
               end
            endcase
         end
         // Overflow never coincides with a pop, so this cannot mask a transition above.
         if (w_ovf_pulse) begin
            r_ovf   <= 1'b1;
            r_state <= S_ERR;
         end
      end
   end

   assign bus.O_VALID = r_o_valid;
   assign bus.O_DATA  = r_o_data;
   assign bus.O_ERR   = r_o_err;
   assign bus.OVF     = r_ovf;

endmodule
